// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: steps through a small program memory and presents
// each word to simple_cpu for a fixed number of clocks, stopping at a HALT word.
module instr_fetch_unit #(
    parameter int INSTR_WIDTH      = 20,
    parameter int PC_BITS          = 5,
    parameter int CYCLES_PER_INSTR = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   issue,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    localparam int DEPTH = 1 << PC_BITS;
    localparam logic [3:0] HOLD_RELOAD = 4'(CYCLES_PER_INSTR - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } state_t;

    state_t                 state;
    logic [3:0]             hold_cnt;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic                   fetch_is_halt;
    logic                   mem_open;

    assign fetch_word    = mem[pc];
    assign fetch_is_halt = (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00);
    // The program may only change while nothing is executing it; reset wins over a write.
    assign mem_open      = !rst && prog_we && (state == IDLE || state == HALTED);

    // Program storage survives reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (mem_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // The instruction register doubles as the registered memory read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            issue       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            issue <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= FETCH;
                        pc          <= '0;
                        instruction <= '0;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_is_halt) begin
                        state       <= HALTED;
                        instruction <= '0;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        state       <= ISSUE;
                        instruction <= fetch_word;
                        issue       <= 1'b1;
                        hold_cnt    <= HOLD_RELOAD;
                    end
                end
                ISSUE: begin
                    if (hold_cnt == 4'd0) begin
                        state       <= FETCH;
                        pc          <= pc + 1'b1;
                        instruction <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter INSTR_WIDTH, default 20, SHALL set the instruction word width.
REQ-002 Parameter PC_BITS, default 5, SHALL set the program-counter width; program memory depth is 2^PC_BITS words.
REQ-003 Parameter CYCLES_PER_INSTR, default 4, legal range 1..15, SHALL set the number of clocks each instruction is presented to simple_cpu.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; sampled only in IDLE or HALTED.
REQ-007 prog_we  input  1  program-memory write enable.
REQ-008 prog_addr  input  PC_BITS  program-memory write address.
REQ-009 prog_data  input  INSTR_WIDTH  program-memory write data.
REQ-010 instruction  output  INSTR_WIDTH  registered word driving the simple_cpu instruction port.
REQ-011 issue  output  1  registered; high on the first cycle a new instruction word is presented.
REQ-012 pc  output  PC_BITS  registered address of the current/next fetch.
REQ-013 busy  output  1  high in FETCH or ISSUE.
REQ-014 halted  output  1  high in HALTED.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, ISSUE, HALTED.
REQ-016 Program memory: 2^PC_BITS x INSTR_WIDTH, synchronous write, registered read; writes SHALL take effect only when prog_we=1 and the state is IDLE or HALTED, and SHALL be ignored otherwise.
REQ-017 IDLE: start=1 -> FETCH, pc=0; otherwise stay.
REQ-018 FETCH (1 cycle): read mem[pc]; if the word's bits [INSTR_WIDTH-1:INSTR_WIDTH-2] equal 2'b00 (HALT) -> HALTED, with instruction=0 and pc unchanged; otherwise -> ISSUE, with instruction=mem[pc] and issue=1 for that one cycle.
REQ-019 ISSUE: instruction SHALL remain stable for exactly CYCLES_PER_INSTR cycles; on the last of those cycles pc SHALL increment by 1 and the next state SHALL be FETCH.
REQ-020 Instruction period SHALL be CYCLES_PER_INSTR+1 clocks: first word visible 2 clocks after start is sampled, with consecutive words CYCLES_PER_INSTR+1 clocks apart.
REQ-021 instruction SHALL be 0 in IDLE, FETCH and HALTED; it SHALL hold the last word only while in ISSUE.
REQ-022 pc wrap-around: increment from 2^PC_BITS-1 SHALL yield 0, and execution SHALL continue without halting.
REQ-023 HALTED: start=1 -> FETCH with pc=0; otherwise stay with halted=1.
REQ-024 start asserted in FETCH or ISSUE SHALL have no effect.
REQ-025 prog_we and start asserted in the same cycle in IDLE: the write SHALL complete and the FSM SHALL enter FETCH; the first fetch SHALL see the newly written data if prog_addr=0.
REQ-026 The internal hold counter SHALL be 4 bits wide and SHALL be reloaded on every FETCH->ISSUE transition.

Reset
REQ-027 rst=1 at any rising edge, including mid-ISSUE, SHALL set state=IDLE, pc=0, instruction=0, issue=0, busy=0, halted=0, and hold counter=0.
REQ-028 Reset SHALL NOT clear program memory; contents are preserved across reset.
REQ-029 rst SHALL take priority over start and prog_we in the same cycle.

Verification
REQ-030 Load mem[0]=20'h47000, mem[1]=20'h53000, mem[2]=20'h72001, mem[3]=0; pulse start -> the three words appear in order, each for 4 clocks, issue pulses 5 clocks apart, then halted=1 with pc=3 and instruction=0.
REQ-031 Fill all 32 words with 20'h47000 and start -> pc wraps 31->0, busy stays 1, and halted never asserts.
REQ-032 Assert rst during the 2nd ISSUE cycle of mem[1] -> on the next clock state=IDLE, pc=0, instruction=0; a restart re-issues mem[0]=20'h47000 unchanged.
REQ-033 Pulse prog_we to address 1 with 20'hDC0F0 while busy -> the write is ignored; after halt, read-back by execution shows the original word.
REQ-034 From HALTED, rewrite mem[3]=20'hB80F0 and mem[4]=0, then start -> execution restarts at pc=0 and 20'hB80F0 is issued as the 4th word.
REQ-035 With CYCLES_PER_INSTR=1, execution SHALL issue a new word every 2 clocks.
